// File: rtl/approx_sub_pkg.sv
// Shared widths and arithmetic helpers for the approximate 8-bit subtractor family.
package approx_sub_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned RES_W  = 9;

  // Low k bits are borrow-free XOR; upper bits subtract exactly with no borrow-in from bit k.
  function automatic logic [RES_W-1:0] approx_sub(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b,
                                                  input int unsigned       k);
    logic [RES_W-1:0]  mask;
    logic [DATA_W-1:0] hi_a;
    logic [DATA_W-1:0] hi_b;
    logic [RES_W-1:0]  diff;
    mask = (RES_W'(1) << k) - RES_W'(1);
    hi_a = a & ~mask[DATA_W-1:0];
    hi_b = b & ~mask[DATA_W-1:0];
    diff = {1'b0, hi_a} - {1'b0, hi_b};
    return (diff & ~mask) | ({1'b0, a ^ b} & mask);
  endfunction

  function automatic logic [RES_W-1:0] abs_err(input logic [RES_W-1:0] exact,
                                               input logic [RES_W-1:0] approx);
    logic signed [RES_W:0] d;
    d = $signed({exact[RES_W-1], exact}) - $signed({approx[RES_W-1], approx});
    if (d < 0) d = -d;
    return d[RES_W-1:0];
  endfunction

endpackage

// File: rtl/approx_sub8u_core.sv
// Combinational approximate unsigned 8-bit subtractor; APPROX_BITS low bits borrow-free.
module approx_sub8u_core
  import approx_sub_pkg::*;
#(
  parameter int unsigned APPROX_BITS = 4
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [RES_W-1:0]  diff_c
);

  assign diff_c = approx_sub(a, b, APPROX_BITS);

endmodule

// File: rtl/approx_sub8u_pipe.sv
// 2-stage valid/ready pipelined approximate subtractor.
// Optional error monitor enabled by defining APPROX_SUB_ERRMON_EN.
module approx_sub8u_pipe
  import approx_sub_pkg::*;
#(
  parameter int unsigned APPROX_BITS = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  O
`ifdef APPROX_SUB_ERRMON_EN
  ,
  input  logic              err_clr,
  output logic [RES_W-1:0]  err_last,
  output logic [RES_W-1:0]  err_max,
  output logic [CNT_W-1:0]  err_cnt
`endif
);

  if (APPROX_BITS > 7 || CNT_W == 0) begin : g_param_chk
    $error("approx_sub8u_pipe: APPROX_BITS must be 0..7 and CNT_W nonzero");
  end

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic              s2_valid_q, s2_valid_d;
  logic [RES_W-1:0]  o_q, o_d;
  logic              s1_adv, s2_adv;
  logic [RES_W-1:0]  core_diff_c;

  assign s2_adv   = ~s2_valid_q | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign in_ready = s1_adv;

  approx_sub8u_core #(.APPROX_BITS(APPROX_BITS)) u_core (
    .a      (a_q),
    .b      (b_q),
    .diff_c (core_diff_c)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    s2_valid_d = s2_valid_q;
    o_d        = o_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        a_d = A;
        b_d = B;
      end
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) o_d = core_diff_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      s2_valid_q <= 1'b0;
      o_q        <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      s2_valid_q <= s2_valid_d;
      o_q        <= o_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign O         = o_q;

`ifdef APPROX_SUB_ERRMON_EN
  logic [RES_W-1:0] exact_q, exact_d;
  logic [RES_W-1:0] err_last_q, err_last_d, err_max_q, err_max_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [RES_W-1:0] err_now_c;

  // Exact difference travels alongside the approximate result in stage 2.
  always_comb begin
    exact_d    = exact_q;
    err_last_d = err_last_q;
    err_max_d  = err_max_q;
    err_cnt_d  = err_cnt_q;
    err_now_c  = abs_err(exact_q, o_q);
    if (s2_adv && s1_valid_q) exact_d = {1'b0, a_q} - {1'b0, b_q};
    if (err_clr) begin
      err_last_d = '0;
      err_max_d  = '0;
      err_cnt_d  = '0;
    end else if (s2_valid_q && out_ready) begin
      err_last_d = err_now_c;
      if (err_now_c > err_max_q) err_max_d = err_now_c;
      if (err_now_c != '0 && err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exact_q    <= '0;
      err_last_q <= '0;
      err_max_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      exact_q    <= exact_d;
      err_last_q <= err_last_d;
      err_max_q  <= err_max_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign err_last = err_last_q;
  assign err_max  = err_max_q;
  assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_approx_sub8u_pipe.sv
// Randomized and directed bench for approx_sub8u_pipe (K=4 and K=0 instances share the handshake).
module tb_approx_sub8u_pipe;

  localparam int unsigned K     = 4;
  localparam int unsigned CNT_W = 16;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } op_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       in_ready, in_ready0;
  logic       out_valid, out_valid0;
  logic [8:0] o_out, o_out0;
`ifdef APPROX_SUB_ERRMON_EN
  logic             err_clr;
  logic [8:0]       err_last, err_max, err_last0, err_max0;
  logic [CNT_W-1:0] err_cnt, err_cnt0;
  int               m_last, m_max, m_cnt;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  op_t  sb[$];
  logic stalled;
  logic [8:0] stall_o;
  logic accepted;

  approx_sub8u_pipe #(.APPROX_BITS(K), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a_in), .B(b_in), .out_valid(out_valid), .out_ready(out_ready), .O(o_out)
`ifdef APPROX_SUB_ERRMON_EN
    , .err_clr(err_clr), .err_last(err_last), .err_max(err_max), .err_cnt(err_cnt)
`endif
  );

  approx_sub8u_pipe #(.APPROX_BITS(0), .CNT_W(CNT_W)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .A(a_in), .B(b_in), .out_valid(out_valid0), .out_ready(out_ready), .O(o_out0)
`ifdef APPROX_SUB_ERRMON_EN
    , .err_clr(err_clr), .err_last(err_last0), .err_max(err_max0), .err_cnt(err_cnt0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: XOR low k bits, exact subtraction of the upper fields wrapped to 9-k bits.
  function automatic logic [8:0] model_sub(input int a, input int b, input int k);
    int lo, hi;
    lo = (a ^ b) % (1 << k);
    hi = (a >> k) - (b >> k);
    if (hi < 0) hi += (1 << (9 - k));
    return 9'((hi << k) + lo);
  endfunction

  function automatic int s9(input logic [8:0] v);
    return v[8] ? int'(v) - 512 : int'(v);
  endfunction

  // One cycle: settle, check, update model, advance to just after the next edge.
  task automatic step();
    op_t        h;
    logic [8:0] e4;
    int         err;
    #1;
`ifdef APPROX_SUB_ERRMON_EN
    check("err_last", int'(err_last), m_last);
    check("err_max", int'(err_max), m_max);
    check("err_cnt", int'(err_cnt), m_cnt);
    check("err_cnt_k0", int'(err_cnt0), 0);
`endif
    check("in_ready", int'(in_ready), int'(!(sb.size() == 2 && !out_ready)));
    check("in_ready_k0", int'(in_ready0), int'(!(sb.size() == 2 && !out_ready)));
    if (sb.size() == 0) check("idle_valid", int'(out_valid), 0);
    if (stalled) begin
      check("stall_O", int'(o_out), int'(stall_o));
      check("stall_valid", int'(out_valid), 1);
    end
    stalled  = out_valid && !out_ready;
    stall_o  = o_out;
    accepted = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", int'(out_valid), 0);
      end else begin
        h  = sb.pop_front();
        e4 = model_sub(int'(h.a), int'(h.b), K);
        check("O", int'(o_out), int'(e4));
        check("O_k0", int'(o_out0), int'(model_sub(int'(h.a), int'(h.b), 0)));
        check("valid_k0", int'(out_valid0), 1);
`ifdef APPROX_SUB_ERRMON_EN
        if (!err_clr) begin
          err = (int'(h.a) - int'(h.b)) - s9(e4);
          if (err < 0) err = -err;
          m_last = err;
          if (err > m_max) m_max = err;
          if (err != 0 && m_cnt != (1 << CNT_W) - 1) m_cnt++;
        end
`endif
      end
    end
`ifdef APPROX_SUB_ERRMON_EN
    if (err_clr) begin
      m_last = 0; m_max = 0; m_cnt = 0;
    end
`endif
    if (accepted) sb.push_back('{a: a_in, b: b_in});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8 && sb.size() != 0; i++) step();
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
  endtask

  // Single transaction into an empty pipe; expects out_valid exactly two edges after acceptance.
  task automatic send_one(input logic [7:0] a, input logic [7:0] b, input logic [8:0] exp_o);
    a_in = a; b_in = b; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("lat1_valid", int'(out_valid), 0);
    step();
    check("lat2_valid", int'(out_valid), 1);
    check("dir_O", int'(o_out), int'(exp_o));
    step();
  endtask

  initial begin
    int sent, cyc;
    logic [7:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
    stalled = 1'b0; stall_o = '0; accepted = 1'b0;
`ifdef APPROX_SUB_ERRMON_EN
    err_clr = 1'b0; m_last = 0; m_max = 0; m_cnt = 0;
`endif
    #3;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_O", int'(o_out), 0);
    check("rst_in_ready", int'(in_ready), 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed vectors
    send_one(8'h35, 8'h17, 9'h022);
`ifdef APPROX_SUB_ERRMON_EN
    check("dir1_err_last", int'(err_last), 4);
    check("dir1_err_cnt", int'(err_cnt), 1);
`endif
    send_one(8'h10, 8'h20, 9'h1F0);
`ifdef APPROX_SUB_ERRMON_EN
    check("dir2_err_last", int'(err_last), 0);
    check("dir2_err_cnt", int'(err_cnt), 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
`endif
    send_one(8'h00, 8'h01, 9'h001);
`ifdef APPROX_SUB_ERRMON_EN
    check("dir3_err_last", int'(err_last), 2);
    check("dir3_err_max", int'(err_max), 2);
    check("dir3_err_cnt", int'(err_cnt), 1);
`endif

    // Exhaustive back-to-back sweep at full throughput
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      a_in = 8'(i >> 8);
      b_in = 8'(i);
      step();
      if (i >= 1) check("throughput", int'(out_valid), 1);
    end
    drain();

    // Random backpressure, producer holds operands while not accepted
    sent = 0; cyc = 0;
    in_valid = 1'b0; accepted = 1'b0;
    while (sent < 1000 && cyc < 20000) begin
      if (!in_valid || accepted) begin
        in_valid = ($urandom_range(0, 3) != 0);
        a_in = 8'($urandom);
        b_in = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 9) >= 3);
      step();
      if (accepted) sent++;
      cyc++;
    end
    if (sent < 1000) check("bp_timeout", sent, 1000);
    drain();

    // Asynchronous reset with two results in flight
    out_ready = 1'b0; in_valid = 1'b1;
    a_in = 8'($urandom); b_in = 8'($urandom);
    step();
    a_in = 8'($urandom); b_in = 8'($urandom);
    step();
    in_valid = 1'b0;
    check("inflight_cnt", sb.size(), 2);
    check("full_in_ready", int'(in_ready), 0);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_O", int'(o_out), 0);
    check("arst_in_ready", int'(in_ready), 1);
    check("arst_O_k0", int'(o_out0), 0);
`ifdef APPROX_SUB_ERRMON_EN
    check("arst_err_last", int'(err_last), 0);
    check("arst_err_max", int'(err_max), 0);
    check("arst_err_cnt", int'(err_cnt), 0);
    m_last = 0; m_max = 0; m_cnt = 0;
`endif
    sb.delete();
    stalled = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rst_hold_valid", int'(out_valid), 0);
    check("rst_hold_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    ra = 8'($urandom); rb = 8'($urandom);
    send_one(ra, rb, model_sub(int'(ra), int'(rb), K));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
